// File: rtl/cipher_word_buffer_pkg.sv
// Shared widths and serializer state encoding for the cipher word buffer.
// Blocks are 64 bits and are emitted as sixteen 4-bit hex nibbles, MSB first.
package cipher_word_buffer_pkg;

    localparam int NIB_W = 4;
    localparam int BLK_W = 64;
    localparam int NIBS  = BLK_W / NIB_W;
    localparam int IDX_W = $clog2(NIBS);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/cipher_word_buffer_word_fifo.sv
// DEPTH x 64-bit word FIFO with registered count/full/empty and a sticky overflow flag.
// The read port is combinational so the serializer can load the head word on its pop cycle.
module cipher_word_buffer_word_fifo
    import cipher_word_buffer_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             push,
    input  logic [BLK_W-1:0] wdata,
    input  logic             pop,
    output logic [BLK_W-1:0] rdata,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty,
    output logic             ovf
);

    localparam int CW = AW + 1;

    logic [BLK_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, empty_q, ovf_q;
    logic             accept;

    // A push is judged against the registered full flag, so it is refused even
    // when a pop frees a slot in the same cycle.
    assign accept = push && !full_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(accept);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(accept) - CW'(pop);
    end

    // NOTE: storage has no reset; only the pointers and flags define what is valid.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == CW'(DEPTH));
            empty_q  <= (count_d == '0);
            ovf_q    <= ovf_q | (push && full_q);
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = full_q;
    assign empty = empty_q;
    assign ovf   = ovf_q;

endmodule

// File: rtl/cipher_word_buffer.sv
// Buffers decrypted 64-bit blocks and serves them to the hex renderer one nibble
// at a time, MSB first, with a one-cycle IDLE bubble between words.
module cipher_word_buffer
    import cipher_word_buffer_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [BLK_W-1:0] din,
    input  logic             din_vld,
    input  logic             rd_req,
    output logic [NIB_W-1:0] nib_out,
    output logic             nib_vld,
    output logic             word_done,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count,
    output logic             ovf
);

    state_t           state_q, state_d;
    logic [BLK_W-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [BLK_W-1:0] head_word;
    logic             pop;

    cipher_word_buffer_word_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk   (clk),
        .clr   (clr),
        .push  (din_vld),
        .wdata (din),
        .pop   (pop),
        .rdata (head_word),
        .count (count),
        .full  (full),
        .empty (empty),
        .ovf   (ovf)
    );

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        idx_d     = idx_q;
        pop       = 1'b0;
        nib_vld   = 1'b0;
        nib_out   = '0;
        word_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shreg_d = head_word;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                nib_vld = 1'b1;
                nib_out = shreg_q[BLK_W-1 -: NIB_W];
                if (rd_req) begin
                    shreg_d = shreg_q << NIB_W;
                    if (idx_q == IDX_W'(NIBS - 1)) begin
                        // A clear in the same cycle abandons the word, so no completion pulse.
                        word_done = !clr;
                        idx_d     = '0;
                        state_d   = IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: tb/tb_cipher_word_buffer.sv
// Directed bench for cipher_word_buffer: inputs change and outputs are sampled on
// the falling edge, so every sample reflects the state after the last rising edge.
module tb_cipher_word_buffer;

    logic        clk;
    logic        clr;
    logic [63:0] din;
    logic        din_vld;
    logic        rd_req;
    logic [3:0]  nib_out;
    logic        nib_vld;
    logic        word_done;
    logic        full;
    logic        empty;
    logic [3:0]  count;
    logic        ovf;

    int checks   = 0;
    int failures = 0;

    cipher_word_buffer #(.DEPTH(8), .AW(3)) dut (
        .clk       (clk),
        .clr       (clr),
        .din       (din),
        .din_vld   (din_vld),
        .rd_req    (rd_req),
        .nib_out   (nib_out),
        .nib_vld   (nib_vld),
        .word_done (word_done),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        clr     = 1'b1;
        din_vld = 1'b0;
        rd_req  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_count", 64'(count), 64'd0);
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_full", 64'(full), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_nib_vld", 64'(nib_vld), 64'd0);
        check("rst_nib_out", 64'(nib_out), 64'd0);
        check("rst_word_done", 64'(word_done), 64'd0);
        clr = 1'b0;
    endtask

    task automatic push(input logic [63:0] w);
        din     = w;
        din_vld = 1'b1;
        @(negedge clk);
        din_vld = 1'b0;
    endtask

    // Reads one whole word, asserting rd_req on every period-th cycle and checking
    // the presented nibble and word_done on every cycle, including held cycles.
    task automatic read_word(input logic [63:0] w, input int period, input string tag);
        int guard = 0;
        int k     = 0;
        int ph    = 0;
        rd_req = 1'b0;
        while (!nib_vld && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!nib_vld) begin
            check({tag, "_timeout"}, 64'(nib_vld), 64'd1);
            return;
        end
        while (k < 16 && ph < 200) begin
            rd_req = ((ph % period) == (period - 1));
            #1;
            check({tag, "_nib"}, 64'(nib_out), 64'(w[63 - 4*k -: 4]));
            check({tag, "_vld"}, 64'(nib_vld), 64'd1);
            check({tag, "_done"}, 64'(word_done), 64'(rd_req && k == 15));
            @(negedge clk);
            if (rd_req) k++;
            ph++;
        end
        rd_req = 1'b0;
        check({tag, "_bubble"}, 64'(nib_vld), 64'd0);
    endtask

    logic [63:0] w;
    int          guard;
    int          max_count;

    initial begin
        din = '0;

        // Single word, continuous reads, exact latency.
        do_reset();
        push(64'heedba5216d8f4b15);
        check("t1_count_n1", 64'(count), 64'd1);
        check("t1_vld_n1", 64'(nib_vld), 64'd0);
        @(negedge clk);
        check("t1_vld_n2", 64'(nib_vld), 64'd1);
        check("t1_first_nib", 64'(nib_out), 64'he);
        read_word(64'heedba5216d8f4b15, 1, "t1");
        check("t1_empty_end", 64'(empty), 64'd1);

        // Fill to full, overflow, drain in order.
        for (int i = 1; i <= 9; i++) push(64'(i));
        check("t2_count_full", 64'(count), 64'd8);
        check("t2_full", 64'(full), 64'd1);
        check("t2_ovf_before", 64'(ovf), 64'd0);
        push(64'd10);
        check("t2_ovf", 64'(ovf), 64'd1);
        check("t2_count_after_ovf", 64'(count), 64'd8);
        for (int i = 1; i <= 9; i++) read_word(64'(i), 1, "t2_drain");
        repeat (3) @(negedge clk);
        check("t2_no_word10", 64'(nib_vld), 64'd0);
        check("t2_empty", 64'(empty), 64'd1);

        // Clear after seven nibbles with three words queued; ovf is still set from above.
        push(64'ha000000000000001);
        push(64'hb000000000000002);
        push(64'hc000000000000003);
        push(64'hd000000000000004);
        check("t5_count_q", 64'(count), 64'd3);
        w = 64'ha000000000000001;
        for (int k = 0; k < 7; k++) begin
            rd_req = 1'b1;
            #1;
            check("t5_part_nib", 64'(nib_out), 64'(w[63 - 4*k -: 4]));
            check("t5_part_done", 64'(word_done), 64'd0);
            @(negedge clk);
        end
        rd_req = 1'b0;
        clr    = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("t5_clr_count", 64'(count), 64'd0);
        check("t5_clr_empty", 64'(empty), 64'd1);
        check("t5_clr_vld", 64'(nib_vld), 64'd0);
        check("t5_clr_ovf", 64'(ovf), 64'd0);
        push(64'hfeedc0de12345678);
        read_word(64'hfeedc0de12345678, 1, "t5_fresh");
        check("t5_empty_end", 64'(empty), 64'd1);

        // Slow reader: one accept every third cycle, nibble held in between.
        do_reset();
        push(64'h0123456789abcdef);
        read_word(64'h0123456789abcdef, 3, "t3");

        // Sustained traffic at the read rate; pointers wrap more than twice.
        do_reset();
        max_count = 0;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    push({32'hc0de0000 + 32'(i), 32'(i * 7 + 3)});
                    repeat (16) @(negedge clk);
                end
            end
            begin
                for (int i = 0; i < 20; i++)
                    read_word({32'hc0de0000 + 32'(i), 32'(i * 7 + 3)}, 1, "t4");
            end
            begin
                repeat (20 * 17 + 10) begin
                    @(negedge clk);
                    if (int'(count) > max_count) max_count = int'(count);
                end
            end
        join
        check("t4_max_count_le2", 64'(max_count <= 2), 64'd1);
        check("t4_ovf", 64'(ovf), 64'd0);
        check("t4_empty", 64'(empty), 64'd1);

        // Simultaneous push and pop at count 4, then at full.
        do_reset();
        for (int i = 0; i < 5; i++) push(64'h5500 + 64'(i));
        check("t6_count4", 64'(count), 64'd4);
        rd_req = 1'b1;
        guard  = 0;
        while (nib_vld && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check("t6_idle_a", 64'(nib_vld), 64'd0);
        check("t6_count4_idle", 64'(count), 64'd4);
        rd_req = 1'b0;
        push(64'h5505);
        check("t6_pushpop_count", 64'(count), 64'd4);
        check("t6_pushpop_vld", 64'(nib_vld), 64'd1);
        for (int i = 6; i < 10; i++) push(64'h5500 + 64'(i));
        check("t6_count8", 64'(count), 64'd8);
        check("t6_full", 64'(full), 64'd1);
        rd_req = 1'b1;
        guard  = 0;
        while (nib_vld && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check("t6_idle_b", 64'(nib_vld), 64'd0);
        check("t6_full_idle", 64'(full), 64'd1);
        rd_req = 1'b0;
        push(64'hdead);
        check("t6_full_pop_count", 64'(count), 64'd7);
        check("t6_full_pop_ovf", 64'(ovf), 64'd1);
        check("t6_full_pop_full", 64'(full), 64'd0);
        for (int i = 2; i < 10; i++) read_word(64'h5500 + 64'(i), 1, "t6_drain");
        check("t6_drain_empty", 64'(empty), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
